// File: rtl/seg_pio_writer_if.sv
// Avalon-MM initiator bundle between seg_pio_writer and the HEX PIO slaves.
interface seg_pio_writer_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/seg_pio_writer.sv
// Encodes a latched set of hex nibbles to 7-segment patterns and writes each one
// to its PIO slave over Avalon-MM, optionally reading it back to verify.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; bus idle
// S_WRITE | write transfer for digit idx in progress
// S_READ  | readback transfer for digit idx in progress
// S_NEXT  | one bus-idle cycle, then advance idx or finish
// S_DONE  | done pulse, busy already low
module seg_pio_writer #(
    parameter int NUM_DIGITS    = 6,
    parameter int ADDR_W        = 16,
    parameter int DIGIT_BASE    = 0,
    parameter int DIGIT_STRIDE  = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1,
    parameter int VERIFY        = 1,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    seg_pio_writer_if.master        avm
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(WAIT_TIMEOUT - 1);
    localparam logic [6:0] BLANK_PAT = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
    logic                    err_q, err_d;
    logic [TMO_W-1:0]        tmo_q;

    logic                    cs_q, wn_q, busy_q, done_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [6:0]              wdata_q;

    logic                    in_xfer, stall, expire;
    logic [NUM_DIGITS:0]     zero_from;
    logic [3:0]              nib_d;
    logic                    blank_d;
    logic [6:0]              pat_d;
    logic [ADDR_W-1:0]       addr_d;
    logic                    unused_rd_hi;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h40;
            4'h1: c = 7'h79;
            4'h2: c = 7'h24;
            4'h3: c = 7'h30;
            4'h4: c = 7'h19;
            4'h5: c = 7'h12;
            4'h6: c = 7'h02;
            4'h7: c = 7'h78;
            4'h8: c = 7'h00;
            4'h9: c = 7'h10;
            4'hA: c = 7'h08;
            4'hB: c = 7'h03;
            4'hC: c = 7'h46;
            4'hD: c = 7'h21;
            4'hE: c = 7'h06;
            default: c = 7'h0E;
        endcase
        return (ACTIVE_LOW != 0) ? c : ~c;
    endfunction

    assign in_xfer = (state_q == S_WRITE) || (state_q == S_READ);
    assign stall   = in_xfer && avm.avm_waitrequest;
    assign expire  = stall && (tmo_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dig_d   = dig_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dig_d   = digits;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (expire) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!avm.avm_waitrequest) begin
                    state_d = (VERIFY != 0) ? S_READ : S_NEXT;
                end
            end
            S_READ: begin
                if (expire) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!avm.avm_waitrequest) begin
                    if (avm.avm_readdata[6:0] != wdata_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_WRITE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pattern and address are computed for the digit about to be written, so they
    // can be registered on the same edge that enters S_WRITE.
    always_comb begin
        zero_from             = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (dig_d[4*i +: 4] == 4'h0);
        end
        nib_d   = 4'h0;
        blank_d = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib_d   = dig_d[4*i +: 4];
                blank_d = (BLANK_LEADING != 0) && (i != 0) && zero_from[i];
            end
        end
        pat_d  = blank_d ? BLANK_PAT : seg_code(nib_d);
        addr_d = ADDR_W'(DIGIT_BASE) + ADDR_W'(DIGIT_STRIDE) * ADDR_W'(idx_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            dig_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            dig_q  <= dig_d;
            err_q  <= err_d;
            if (stall && !expire) begin
                tmo_q <= tmo_q - TMO_W'(1);
            end else if ((state_d == S_WRITE) || (state_d == S_READ)) begin
                tmo_q <= TMO_LOAD;
            end else begin
                tmo_q <= '0;
            end
            cs_q   <= (state_d == S_WRITE) || (state_d == S_READ);
            wn_q   <= (state_d != S_WRITE);
            busy_q <= (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_NEXT);
            done_q <= (state_d == S_DONE);
            if (state_d == S_WRITE) begin
                addr_q  <= addr_d;
                wdata_q <= pat_d;
            end
        end
    end

    assign avm.avm_chipselect = cs_q;
    assign avm.avm_write_n    = wn_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_writedata  = {25'b0, wdata_q};
    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = err_q;

    // Only the segment bits of the readback matter.
    assign unused_rd_hi = ^avm.avm_readdata[31:7];

endmodule

// File: tb/tb_seg_pio_writer.sv
// Directed bench for seg_pio_writer: two instances (default, and unblanked with short
// timeout) each talking to a small PIO slave model that logs completed writes.
module tb_seg_pio_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [23:0] digits_a, digits_b;
    logic        busy_a, done_a, error_a;
    logic        busy_b, done_b, error_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_pio_writer_if #(.ADDR_W(16)) a_if ();
    seg_pio_writer_if #(.ADDR_W(16)) b_if ();

    seg_pio_writer u_a (
        .clk    (clk),
        .reset  (reset),
        .start  (start_a),
        .digits (digits_a),
        .busy   (busy_a),
        .done   (done_a),
        .error  (error_a),
        .avm    (a_if)
    );

    seg_pio_writer #(
        .BLANK_LEADING (0),
        .WAIT_TIMEOUT  (8)
    ) u_b (
        .clk    (clk),
        .reset  (reset),
        .start  (start_b),
        .digits (digits_b),
        .busy   (busy_b),
        .done   (done_b),
        .error  (error_b),
        .avm    (b_if)
    );

    // Slave A: optional stall on one write address, optional corrupt readback of address 4.
    logic [15:0] a_stall_addr;
    int          a_stall_n;
    int          a_wait_cnt   = 0;
    int          a_stall_good = 0;
    logic        a_bad_rd;
    int          a_wn = 0;
    logic [15:0] a_log_addr [0:63];
    logic [31:0] a_log_data [0:63];
    logic [6:0]  a_mem      [0:7];

    assign a_if.avm_waitrequest = a_if.avm_chipselect && !a_if.avm_write_n &&
                                  (a_if.avm_address == a_stall_addr) && (a_wait_cnt < a_stall_n);
    assign a_if.avm_readdata = {25'h1555555,
        (a_bad_rd && a_if.avm_address == 16'd4) ? 7'h00 : a_mem[a_if.avm_address[4:2]]};

    always @(posedge clk) begin
        if (a_if.avm_chipselect && !a_if.avm_write_n && !a_if.avm_waitrequest) begin
            if (a_wn < 64) begin
                a_log_addr[a_wn] <= a_if.avm_address;
                a_log_data[a_wn] <= a_if.avm_writedata;
            end
            a_mem[a_if.avm_address[4:2]] <= a_if.avm_writedata[6:0];
            a_wn <= a_wn + 1;
        end
        if (a_if.avm_chipselect && !a_if.avm_write_n && a_if.avm_address == a_stall_addr)
            a_wait_cnt <= a_wait_cnt + 1;
        else
            a_wait_cnt <= 0;
        if (a_if.avm_waitrequest && !a_if.avm_write_n && a_if.avm_address == 16'd8 &&
            a_if.avm_writedata == 32'h30)
            a_stall_good <= a_stall_good + 1;
    end

    // Slave B: zero-wait unless stuck.
    logic        b_stuck;
    int          b_wn = 0;
    logic [15:0] b_log_addr [0:63];
    logic [31:0] b_log_data [0:63];
    logic [6:0]  b_mem      [0:7];

    assign b_if.avm_waitrequest = b_stuck;
    assign b_if.avm_readdata    = {25'h0, b_mem[b_if.avm_address[4:2]]};

    always @(posedge clk) begin
        if (b_if.avm_chipselect && !b_if.avm_write_n && !b_if.avm_waitrequest) begin
            if (b_wn < 64) begin
                b_log_addr[b_wn] <= b_if.avm_address;
                b_log_data[b_wn] <= b_if.avm_writedata;
            end
            b_mem[b_if.avm_address[4:2]] <= b_if.avm_writedata[6:0];
            b_wn <= b_wn + 1;
        end
    end

    logic s_cs [0:127];
    logic s_busy [0:127];
    logic s_done [0:127];
    logic s_err [0:127];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] code_tbl(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h40; 4'h1: c = 7'h79; 4'h2: c = 7'h24; 4'h3: c = 7'h30;
            4'h4: c = 7'h19; 4'h5: c = 7'h12; 4'h6: c = 7'h02; 4'h7: c = 7'h78;
            4'h8: c = 7'h00; 4'h9: c = 7'h10; 4'hA: c = 7'h08; 4'hB: c = 7'h03;
            4'hC: c = 7'h46; 4'hD: c = 7'h21; 4'hE: c = 7'h06; default: c = 7'h0E;
        endcase
        return c;
    endfunction

    function automatic logic [6:0] model_pat(input logic [23:0] d, input int i, input bit bl);
        bit z;
        z = 1'b1;
        for (int k = i; k < 6; k++) if (d[4*k +: 4] != 4'h0) z = 1'b0;
        if (bl && i > 0 && z) return 7'h7F;
        return code_tbl(d[4*i +: 4]);
    endfunction

    // Start one sequence and sample every cycle until done; inj pulses a stray start on A.
    task automatic run(input bit sel, input logic [23:0] d, input int inj, output int cyc);
        cyc = 0;
        for (int k = 0; k < 128; k++) begin
            s_cs[k] = 1'b0; s_busy[k] = 1'b0; s_done[k] = 1'b0; s_err[k] = 1'b0;
        end
        @(negedge clk);
        if (sel) begin digits_b = d; start_b = 1'b1; end
        else     begin digits_a = d; start_a = 1'b1; end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int n = 1; n <= 100 && cyc == 0; n++) begin
            @(negedge clk);
            s_cs[n]   = sel ? b_if.avm_chipselect : a_if.avm_chipselect;
            s_busy[n] = sel ? busy_b : busy_a;
            s_done[n] = sel ? done_b : done_a;
            s_err[n]  = sel ? error_b : error_a;
            if (!sel && n == inj) begin
                start_a  = 1'b1;
                digits_a = 24'hFFFFFF;
            end else begin
                start_a = 1'b0;
            end
            if (s_done[n]) cyc = n;
        end
        chk("run_done_seen", 32'(cyc != 0), 32'd1);
    endtask

    task automatic chk_log(input bit sel, input int base, input logic [23:0] d, input bit bl,
                           input string tag);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_addr%0d", tag, i),
                sel ? 32'(b_log_addr[base+i]) : 32'(a_log_addr[base+i]), 32'(i * 4));
            chk($sformatf("%s_data%0d", tag, i),
                sel ? b_log_data[base+i] : a_log_data[base+i], {25'b0, model_pat(d, i, bl)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=time_expired expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        int sg;

        reset        = 1'b1;
        start_a      = 1'b0;
        start_b      = 1'b0;
        digits_a     = '0;
        digits_b     = '0;
        a_stall_addr = 16'd8;
        a_stall_n    = 0;
        a_bad_rd     = 1'b0;
        b_stuck      = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_cs",    32'(a_if.avm_chipselect), 32'd0);
        chk("rst_wn",    32'(a_if.avm_write_n),    32'd1);
        chk("rst_addr",  32'(a_if.avm_address),    32'd0);
        chk("rst_wdata", a_if.avm_writedata,       32'd0);
        chk("rst_busy",  32'(busy_a),              32'd0);
        chk("rst_done",  32'(done_a),              32'd0);
        chk("rst_err",   32'(error_a),             32'd0);
        chk("rst_b_cs",  32'(b_if.avm_chipselect), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy_a), 32'd0);

        // Blanked leading zeros, zero-wait, verified.
        base = a_wn;
        run(1'b0, 24'h000042, 0, cyc);
        chk("t1_cycles",    32'(cyc),       32'd19);
        chk("t1_busy_c1",   32'(s_busy[1]), 32'd1);
        chk("t1_cs_c3",     32'(s_cs[3]),   32'd0);
        chk("t1_busy_c18",  32'(s_busy[18]), 32'd1);
        chk("t1_busy_done", 32'(s_busy[19]), 32'd0);
        chk("t1_err",       32'(s_err[19]), 32'd0);
        chk("t1_nwrites",   32'(a_wn - base), 32'd6);
        chk("t1_d0",        a_log_data[base],   32'h24);
        chk("t1_d1",        a_log_data[base+1], 32'h19);
        chk("t1_d5_blank",  a_log_data[base+5], 32'h7F);
        chk_log(1'b0, base, 24'h000042, 1'b1, "t1");
        @(negedge clk);
        chk("t1_done_pulse", 32'(done_a), 32'd0);

        // No blanking: zeros, then every hex code.
        base = b_wn;
        run(1'b1, 24'h000000, 0, cyc);
        chk("t2_cycles", 32'(cyc), 32'd19);
        chk("t2_d5_zero", b_log_data[base+5], 32'h40);
        chk_log(1'b1, base, 24'h000000, 1'b0, "t2z");
        base = b_wn;
        run(1'b1, 24'h543210, 0, cyc);
        chk_log(1'b1, base, 24'h543210, 1'b0, "t2a");
        base = b_wn;
        run(1'b1, 24'hBA9876, 0, cyc);
        chk("t2_B", b_log_data[base+5], 32'h03);
        chk_log(1'b1, base, 24'hBA9876, 1'b0, "t2b");
        base = b_wn;
        run(1'b1, 24'hFEDCBA, 0, cyc);
        chk("t2_F", b_log_data[base+5], 32'h0E);
        chk("t2_C", b_log_data[base+2], 32'h46);
        chk_log(1'b1, base, 24'hFEDCBA, 1'b0, "t2c");

        // Three wait states on digit 2 write.
        base      = a_wn;
        sg        = a_stall_good;
        a_stall_n = 3;
        run(1'b0, 24'h654321, 0, cyc);
        a_stall_n = 0;
        chk("t3_cycles",     32'(cyc), 32'd22);
        chk("t3_stall_hold", 32'(a_stall_good - sg), 32'd3);
        chk("t3_err",        32'(s_err[22]), 32'd0);
        chk("t3_nwrites",    32'(a_wn - base), 32'd6);
        chk_log(1'b0, base, 24'h654321, 1'b1, "t3");

        // Corrupt readback of digit 1.
        base     = a_wn;
        a_bad_rd = 1'b1;
        run(1'b0, 24'h000042, 0, cyc);
        a_bad_rd = 1'b0;
        chk("t4_err_c5",   32'(s_err[5]), 32'd0);
        chk("t4_err_c6",   32'(s_err[6]), 32'd1);
        chk("t4_err_done", 32'(s_err[19]), 32'd1);
        chk("t4_cycles",   32'(cyc), 32'd19);
        chk("t4_nwrites",  32'(a_wn - base), 32'd6);
        chk_log(1'b0, base, 24'h000042, 1'b1, "t4");
        run(1'b0, 24'h000042, 0, cyc);
        chk("t4_err_clr",  32'(s_err[1]), 32'd0);
        chk("t4_err_end",  32'(s_err[19]), 32'd0);

        // Slave stuck in waitrequest, timeout 8.
        base    = b_wn;
        b_stuck = 1'b1;
        run(1'b1, 24'h000042, 0, cyc);
        b_stuck = 1'b0;
        chk("t5_cycles",    32'(cyc), 32'd9);
        chk("t5_cs_c1",     32'(s_cs[1]), 32'd1);
        chk("t5_cs_c8",     32'(s_cs[8]), 32'd1);
        chk("t5_cs_c9",     32'(s_cs[9]), 32'd0);
        chk("t5_err",       32'(s_err[9]), 32'd1);
        chk("t5_busy_done", 32'(s_busy[9]), 32'd0);
        chk("t5_nwrites",   32'(b_wn - base), 32'd0);
        @(negedge clk);
        chk("t5_idle_busy", 32'(busy_b), 32'd0);
        chk("t5_idle_done", 32'(done_b), 32'd0);

        // Stray start while busy is ignored and not queued.
        base = a_wn;
        run(1'b0, 24'h000042, 2, cyc);
        chk("t6_cycles", 32'(cyc), 32'd19);
        chk("t6_nwrites", 32'(a_wn - base), 32'd6);
        chk_log(1'b0, base, 24'h000042, 1'b1, "t6");
        repeat (3) @(negedge clk);
        chk("t6_no_queue_busy", 32'(busy_a), 32'd0);
        chk("t6_no_queue_cs",   32'(a_if.avm_chipselect), 32'd0);

        // Reset in the middle of the digit 1 write.
        base = a_wn;
        @(negedge clk);
        digits_a = 24'h000042;
        start_a  = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_mid_cs",   32'(a_if.avm_chipselect), 32'd1);
        chk("t6_mid_addr", 32'(a_if.avm_address),    32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_cs",    32'(a_if.avm_chipselect), 32'd0);
        chk("t6_rst_wn",    32'(a_if.avm_write_n),    32'd1);
        chk("t6_rst_addr",  32'(a_if.avm_address),    32'd0);
        chk("t6_rst_wdata", a_if.avm_writedata,       32'd0);
        chk("t6_rst_busy",  32'(busy_a),              32'd0);
        chk("t6_rst_done",  32'(done_a),              32'd0);
        chk("t6_rst_err",   32'(error_a),             32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_partial_writes", 32'(a_wn - base), 32'd1);
        base = a_wn;
        run(1'b0, 24'h000042, 0, cyc);
        chk("t6_after_cycles", 32'(cyc), 32'd19);
        chk("t6_after_err",    32'(s_err[19]), 32'd0);
        chk_log(1'b0, base, 24'h000042, 1'b1, "t6r");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
